// File: rtl/manchester_lock_controller.sv
// Manchester half-bit period acquisition and tracking.
// The controller measures the spacing between line edges. It trains an
// initial half-bit period from the smallest valid interval it sees. Once
// locked, it tracks that period and classifies each edge as short or long.
// There is no valid/ready handshake here. Every output is a registered level
// or a one-cycle pulse. A pulse appears in the cycle after the edge that
// caused it.
module manchester_lock_controller #(
    parameter int unsigned W              = 8,
    parameter int unsigned DEFAULT_PERIOD = 10,
    parameter int unsigned MIN_PERIOD     = 3,
    parameter int unsigned TRAIN_EDGES    = 8,
    parameter int unsigned TOL            = 1,
    parameter int unsigned MISS_LIMIT     = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic         pos_edge,
    input  logic         neg_edge,
    output logic [W-1:0] period,
    output logic         locked,
    output logic         period_update,
    output logic         edge_short,
    output logic         edge_long,
    output logic         lock_lost,
    output logic [1:0]   state_dbg
);

    localparam int unsigned TCW = $clog2(TRAIN_EDGES + 1);
    localparam int unsigned MCW = $clog2(MISS_LIMIT + 1);

    localparam logic [W-1:0]   MAX_V   = '1;
    localparam logic [W-1:0]   DEF_P   = W'(DEFAULT_PERIOD);
    localparam logic [W-1:0]   MIN_P   = W'(MIN_PERIOD);
    localparam logic [TCW-1:0] TRAIN_N = TCW'(TRAIN_EDGES);
    localparam logic [MCW-1:0] MISS_N  = MCW'(MISS_LIMIT);
    localparam logic [W+1:0]   TOL1    = (W+2)'(TOL);
    localparam logic [W+1:0]   TOL2    = (W+2)'(2 * TOL);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRAIN  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   cnt, cnt_n;
    logic [W-1:0]   period_n, min_q, min_n, min_cand, step_p;
    logic [TCW-1:0] train_cnt, train_n;
    logic [MCW-1:0] miss_cnt, miss_n;
    logic           upd_n, short_n, long_n, lost_n, drop;

    // Simultaneous rising and falling pulses count as a single edge.
    logic         line_edge;
    // The interval, the period and its multiples are widened by two bits,
    // so the compares below cannot overflow.
    logic [W+1:0] iv_x, p_x, p2_x, p4_x, d_short, d_long;

    assign line_edge = pos_edge | neg_edge;
    assign iv_x      = {2'b00, cnt};
    assign p_x       = {2'b00, period};
    assign p2_x      = {1'b0, period, 1'b0};
    assign p4_x      = {period, 2'b00};
    assign d_short   = (iv_x >= p_x)  ? (iv_x - p_x)  : (p_x - iv_x);
    assign d_long    = (iv_x >= p2_x) ? (iv_x - p2_x) : (p2_x - iv_x);
    assign min_cand  = (cnt < min_q) ? cnt : min_q;
    assign locked    = (state == LOCKED);
    assign state_dbg = state;

    // Next-state logic: counter, training, tracking and pulse generation.
    always_comb begin
        state_n  = state;
        cnt_n    = line_edge ? W'(1) : ((cnt == MAX_V) ? cnt : cnt + W'(1));
        period_n = period;
        train_n  = train_cnt;
        miss_n   = miss_cnt;
        min_n    = min_q;
        upd_n    = 1'b0;
        short_n  = 1'b0;
        long_n   = 1'b0;
        lost_n   = 1'b0;
        drop     = 1'b0;
        step_p   = period;

        if (!enable) begin
            lost_n   = (state == LOCKED);
            upd_n    = (period != DEF_P);
            state_n  = SEARCH;
            cnt_n    = '0;
            period_n = DEF_P;
            train_n  = '0;
            miss_n   = '0;
            min_n    = MAX_V;
        end else begin
            case (state)
                SEARCH: begin
                    if (line_edge) state_n = TRAIN;
                end
                TRAIN: begin
                    if (line_edge) begin
                        if (cnt >= MIN_P) begin
                            train_n = train_cnt + TCW'(1);
                            min_n   = min_cand;
                            if (train_cnt + TCW'(1) == TRAIN_N) begin
                                period_n = min_cand;
                                upd_n    = 1'b1;
                                state_n  = LOCKED;
                                miss_n   = '0;
                                train_n  = '0;
                                min_n    = MAX_V;
                            end
                        end
                    end else if (cnt == MAX_V) begin
                        // The line went quiet, so restart acquisition.
                        state_n = SEARCH;
                        train_n = '0;
                        min_n   = MAX_V;
                    end
                end
                LOCKED: begin
                    if (line_edge) begin
                        if (d_short <= TOL1) begin
                            if (iv_x > p_x && period != MAX_V)
                                step_p = period + W'(1);
                            else if (iv_x < p_x && period > MIN_P)
                                step_p = period - W'(1);
                            short_n  = 1'b1;
                            miss_n   = '0;
                            period_n = step_p;
                            upd_n    = (step_p != period);
                        end else if (d_long <= TOL2) begin
                            long_n = 1'b1;
                            miss_n = '0;
                        end else if (miss_cnt + MCW'(1) >= MISS_N) begin
                            drop = 1'b1;
                        end else begin
                            miss_n = miss_cnt + MCW'(1);
                        end
                    end else if (iv_x > p4_x) begin
                        drop = 1'b1;
                    end
                end
                default: state_n = SEARCH;
            endcase

            if (drop) begin
                state_n  = SEARCH;
                lost_n   = 1'b1;
                period_n = DEF_P;
                upd_n    = (period != DEF_P);
                miss_n   = '0;
                train_n  = '0;
                min_n    = MAX_V;
            end
        end
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= SEARCH;
            cnt           <= '0;
            period        <= DEF_P;
            train_cnt     <= '0;
            miss_cnt      <= '0;
            min_q         <= MAX_V;
            period_update <= 1'b0;
            edge_short    <= 1'b0;
            edge_long     <= 1'b0;
            lock_lost     <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            period        <= period_n;
            train_cnt     <= train_n;
            miss_cnt      <= miss_n;
            min_q         <= min_n;
            period_update <= upd_n;
            edge_short    <= short_n;
            edge_long     <= long_n;
            lock_lost     <= lost_n;
        end
    end

endmodule

// File: tb/tb_manchester_lock_controller.sv
// Bench for manchester_lock_controller. An event-level reference model
// tracks the time since the last edge, the list of training intervals and
// the current period. The model predicts every output, every cycle.
module tb_manchester_lock_controller;

    logic       clock = 1'b0;
    logic       reset, enable, pos_edge, neg_edge;
    logic [7:0] period;
    logic       locked, period_update, edge_short, edge_long, lock_lost;
    logic [1:0] state_dbg;

    manchester_lock_controller dut (
        .clock(clock), .reset(reset), .enable(enable),
        .pos_edge(pos_edge), .neg_edge(neg_edge),
        .period(period), .locked(locked), .period_update(period_update),
        .edge_short(edge_short), .edge_long(edge_long),
        .lock_lost(lock_lost), .state_dbg(state_dbg)
    );

    // Clock generation
    always #5 clock = ~clock;

    // Observed vector: {period, locked, period_update, edge_short, edge_long, lock_lost}
    logic [12:0] dut_vec;
    assign dut_vec = {period, locked, period_update, edge_short, edge_long, lock_lost};

    logic [12:0] exp_q[$];
    logic [12:0] obs_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state: 0 searching, 1 training, 2 locked
    int m_cycle = 0;
    int m_ref = 0;
    int m_mode = 0;
    int m_period = 10;
    int m_miss = 0;
    int m_train[$];

    // Apply one cycle of stimulus, advance the model, record observed/expected.
    task automatic step(input bit p, input bit n, input bit en, input bit r);
        int iv, dev, dev2, np, lo;
        bit ed, upd, sh, lg, lost, drop;
        reset = r; enable = en; pos_edge = p; neg_edge = n;
        iv = m_cycle - m_ref;
        if (iv > 255) iv = 255;
        ed = p | n;
        upd = 0; sh = 0; lg = 0; lost = 0; drop = 0;
        if (r) begin
            m_mode = 0; m_period = 10; m_miss = 0; m_train.delete();
            m_ref = m_cycle + 1;
        end else if (!en) begin
            lost = (m_mode == 2);
            upd = (m_period != 10);
            m_mode = 0; m_period = 10; m_miss = 0; m_train.delete();
            m_ref = m_cycle + 1;
        end else if (ed) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (iv >= 3) begin
                    m_train.push_back(iv);
                    if (m_train.size() == 8) begin
                        lo = 1 << 30;
                        foreach (m_train[i]) if (m_train[i] < lo) lo = m_train[i];
                        m_period = lo; upd = 1; m_mode = 2; m_miss = 0;
                        m_train.delete();
                    end
                end
            end else begin
                dev  = (iv > m_period) ? iv - m_period : m_period - iv;
                dev2 = (iv > 2*m_period) ? iv - 2*m_period : 2*m_period - iv;
                if (dev <= 1) begin
                    sh = 1; m_miss = 0;
                    np = m_period;
                    if (iv > m_period) np = m_period + 1;
                    if (iv < m_period) np = m_period - 1;
                    if (np < 3) np = 3;
                    if (np > 255) np = 255;
                    upd = (np != m_period);
                    m_period = np;
                end else if (dev2 <= 2) begin
                    lg = 1; m_miss = 0;
                end else begin
                    m_miss++;
                    if (m_miss >= 3) drop = 1;
                end
            end
            m_ref = m_cycle;
        end else begin
            if (m_mode == 1 && iv == 255) begin
                m_mode = 0; m_train.delete();
            end
            if (m_mode == 2 && iv > 4*m_period) drop = 1;
        end
        if (drop) begin
            lost = 1; upd = (m_period != 10);
            m_period = 10; m_mode = 0; m_miss = 0; m_train.delete();
        end
        m_cycle++;
        @(posedge clock);
        #1;
        exp_q.push_back({m_period[7:0], m_mode == 2, upd, sh, lg, lost});
        obs_q.push_back(dut_vec);
    endtask

    // n cycles, optionally ending in an edge of random polarity (pos, neg or both).
    task automatic gap(input int n, input bit en, input bit with_edge);
        int sel;
        for (int k = 1; k <= n; k++) begin
            sel = $urandom_range(0, 2);
            step(with_edge && k == n && sel != 1, with_edge && k == n && sel != 0, en, 1'b0);
        end
    endtask

    task automatic acquire_at_10();
        gap(4, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) gap(10, 1'b1, 1'b1);
    endtask

    task automatic test_reset();
        logic [12:0] o, x;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL reset: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_acquire();
        logic [12:0] o, x;
        acquire_at_10();
        for (int i = 0; i < 4; i++) gap(10, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL acquire: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_short_long();
        logic [12:0] o, x;
        int choices[4] = '{10, 20, 19, 21};
        for (int i = 0; i < 16; i++) gap(choices[$urandom_range(0, 3)], 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL short_long: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_drift_and_glitch();
        logic [12:0] o, x;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        gap(4, 1'b1, 1'b1);
        gap(10, 1'b1, 1'b1);
        gap(10, 1'b1, 1'b1);
        gap(2, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) gap(10, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) gap(11, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL drift_glitch: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_miss();
        logic [12:0] o, x;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        acquire_at_10();
        gap(15, 1'b1, 1'b1); gap(15, 1'b1, 1'b1); gap(10, 1'b1, 1'b1);
        gap(15, 1'b1, 1'b1); gap(15, 1'b1, 1'b1); gap(15, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) gap(10, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL miss: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_timeout_enable();
        logic [12:0] o, x;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        acquire_at_10();
        gap(50, 1'b1, 1'b0);
        acquire_at_10();
        gap(11, 1'b1, 1'b1);
        gap(3, 1'b0, 1'b1);
        gap(3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) gap(10, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL timeout_enable: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_reset_mid_train_and_saturation();
        logic [12:0] o, x;
        gap(4, 1'b1, 1'b1);
        gap(12, 1'b1, 1'b1);
        gap(12, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        gap(5, 1'b1, 1'b1);
        gap(300, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) gap(9, 1'b1, 1'b1);
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL reset_mid_train_sat: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    task automatic test_random();
        logic [12:0] o, x;
        int gaps[12] = '{2, 4, 5, 9, 10, 11, 12, 15, 19, 20, 21, 45};
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 40) == 0) gap($urandom_range(1, 3), 1'b0, 1'b0);
            else if (i % 50 < 25) gap($urandom_range(9, 11), 1'b1, 1'b1);
            else gap(gaps[$urandom_range(0, 11)], 1'b1, 1'b1);
        end
        while (exp_q.size() > 0) begin
            o = obs_q.pop_front(); x = exp_q.pop_front(); vectors++;
            if (o !== x) begin
                miscompares++;
                $display("FAIL random: got %h want %h (state %0d)", o, x, state_dbg);
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; pos_edge = 1'b0; neg_edge = 1'b0;
        test_reset();
        test_acquire();
        test_short_long();
        test_drift_and_glitch();
        test_miss();
        test_timeout_enable();
        test_reset_mid_train_and_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/manchester_lock_controller.md
Name: manchester_lock_controller

Overview:
Sequences acquisition and tracking of the Manchester half-bit period for the clock recovery datapath. Measures intervals between edge-detector pulses, trains an initial half-bit period estimate, then tracks it while locked. Outputs a configured period, lock status and per-edge short/long classification. Sits between the edge detector and the clock recovery/decoder stages.

Parameters:
W, 8, width of interval counter and period register
DEFAULT_PERIOD, 10, period output while not locked
MIN_PERIOD, 3, intervals below this are glitches and are ignored in training
TRAIN_EDGES, 8, intervals collected in TRAIN before locking
TOL, 1, classification tolerance in cycles (short: ±TOL, long: ±2*TOL)
MISS_LIMIT, 3, consecutive invalid intervals in LOCKED that drop lock

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
enable  input  1  low forces SEARCH; all pulses suppressed
pos_edge  input  1  one-cycle rising-edge pulse on line
neg_edge  input  1  one-cycle falling-edge pulse on line
period  output  W  current half-bit period estimate
locked  output  1  high in LOCKED
period_update  output  1  one-cycle pulse when period changes value
edge_short  output  1  one-cycle pulse: interval classified half-bit (LOCKED only)
edge_long  output  1  one-cycle pulse: interval classified full-bit (LOCKED only)
lock_lost  output  1  one-cycle pulse on LOCKED -> SEARCH

Behaviour:
- Reset (clock was decided: clock; reset decided: reset, synchronous, active-high): state=SEARCH, period=DEFAULT_PERIOD, counter=0, all pulses 0, locked=0, train/miss counters 0, min register = all ones.
- edge = pos_edge | neg_edge; both high same cycle = one edge.
- Interval counter: edge cycle loads 1; otherwise increments, saturating at 2^W-1. Interval captured on an edge = counter value before load, so edges N cycles apart give interval N.
- All outputs registered; pulses appear the cycle after the edge cycle.
- SEARCH: first edge -> TRAIN (counter loaded, no interval used). period held at DEFAULT_PERIOD.
- TRAIN: each edge with interval >= MIN_PERIOD increments train count and updates min = min(min, interval); intervals < MIN_PERIOD ignored (not counted). On TRAIN_EDGES-th counted interval: period <= min, period_update pulse, -> LOCKED, miss=0. Counter saturation in TRAIN -> SEARCH (no lock_lost pulse), min reset.
- LOCKED, per edge (comparisons in W+2 bits, no overflow):
  short if |interval - period| <= TOL: edge_short; if interval > period then period+1, if < then period-1 (never below MIN_PERIOD, never above 2^W-1); period_update when value changes; miss=0.
  else long if |interval - 2*period| <= 2*TOL: edge_long; miss=0; period unchanged.
  else invalid: miss+1; reaching MISS_LIMIT -> SEARCH, lock_lost, locked=0, period=DEFAULT_PERIOD.
- LOCKED timeout: counter > 4*period with no edge -> SEARCH, lock_lost, period=DEFAULT_PERIOD.
- Transition to SEARCH from LOCKED asserts period_update if period value changes.
- enable low: next cycle state=SEARCH, locked=0, period=DEFAULT_PERIOD, counters cleared; lock_lost pulses if leaving LOCKED. enable dominates edges.
- Reset mid-operation overrides everything in that cycle.

Test Plan:
- Edges every 10 cycles, 9 edges after reset -> period=10, period_update and locked=1 one cycle after 9th edge; subsequent edges give edge_short only.
- Locked at 10, mix intervals 10 and 20 -> edge_short/edge_long pulses matching, period stays 10, no period_update.
- Locked at 10, intervals drift to 11 -> period steps to 11 with one period_update; interval 2 in TRAIN ignored (train count unchanged).
- Locked at 10, three intervals of 15 -> lock_lost pulse after 3rd, locked=0, period=10 (DEFAULT), state SEARCH; two bad then one good -> stays locked.
- Locked at 10, no edges -> lock_lost at counter 41 cycles after last edge; enable dropped while LOCKED -> lock_lost next cycle, later edges produce no pulses.
- pos_edge and neg_edge same cycle -> counted as single edge; reset asserted mid-TRAIN -> all outputs at reset values next cycle.
